split_queue_target: RTL and testbench



---
 rtl/split_queue_target.sv | 183 ++++++++++++++++++
 tb/tb_split_queue_target.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_queue_target.sv
`default_nettype none
// ============================================================================
// Module      : split_queue_target
// Description : Split-capable bus target. Writes are acknowledged in place;
//               reads are split-acked, snapshotted into a pending FIFO and
//               returned later through an arbitrated split_req/split_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module split_queue_target #(
  parameter int INTERNAL_ADDR_BITS = 12,
  parameter int READ_LATENCY       = 4,
  parameter int QUEUE_DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target_addr_in,
  input  logic        target_addr_in_valid,
  input  logic [7:0]  target_data_in,
  input  logic        target_data_in_valid,
  input  logic        target_rw,
  input  logic        split_grant,
  output logic        split_req,
  output logic [7:0]  target_data_out,
  output logic        target_data_out_valid,
  output logic        target_ack,
  output logic        target_split_ack,
  output logic        target_ready,
  output logic [7:0]  split_target_last_write
);

  localparam int c_MEM_DEPTH = 1 << INTERNAL_ADDR_BITS;
  localparam int c_PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int c_CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int c_LAT_W     = $clog2(READ_LATENCY + 1);

  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LATENCY);
  localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

  localparam logic [1:0] c_RET_IDLE = 2'd0;
  localparam logic [1:0] c_RET_WAIT = 2'd1;
  localparam logic [1:0] c_RET_REQ  = 2'd2;
  localparam logic [1:0] c_RET_DATA = 2'd3;

  logic [7:0]         mem_q  [0:c_MEM_DEPTH-1];
  logic [7:0]         fifo_q [0:QUEUE_DEPTH-1];

  logic [1:0]         state_q, state_d;
  logic [c_LAT_W-1:0] lat_q, lat_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic               resp_q;
  logic               ack_q;
  logic               split_ack_q;
  logic [7:0]         data_out_q;
  logic [7:0]         last_write_q;

  logic [INTERNAL_ADDR_BITS-1:0] w_addr;
  logic                          w_accept;
  logic                          w_wr_acc;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_grant;

  // Upper address bits are decoded by the bus, not here.
  if (INTERNAL_ADDR_BITS < 16) begin : g_addr_upper
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^target_addr_in[15:INTERNAL_ADDR_BITS];
  end : g_addr_upper

  assign w_addr   = target_addr_in[INTERNAL_ADDR_BITS-1:0];
  assign w_accept = target_addr_in_valid & target_ready;
  assign w_wr_acc = w_accept & target_rw & target_data_in_valid;
  assign w_push   = w_accept & ~target_rw;
  assign w_grant  = (state_q == c_RET_REQ) & split_grant;

  assign target_ready = (count_q != c_CNT_FULL) & (state_q != c_RET_DATA) & ~resp_q;

  assign split_req               = (state_q == c_RET_REQ);
  assign target_data_out_valid   = (state_q == c_RET_DATA);
  assign target_data_out         = data_out_q;
  assign target_ack              = ack_q;
  assign target_split_ack        = split_ack_q;
  assign split_target_last_write = last_write_q;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[w_addr] <= target_data_in;
    end
  end

  // The read value is captured at accept so later writes cannot alter it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[tail_q] <= mem_q[w_addr];
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    w_pop   = 1'b0;
    case (state_q)
      c_RET_IDLE: begin
        if (w_push || (count_q != '0)) begin
          state_d = c_RET_WAIT;
          lat_d   = c_LAT_LOAD;
        end
      end
      c_RET_WAIT: begin
        if (lat_q == c_LAT_ONE) begin
          state_d = c_RET_REQ;
        end else begin
          lat_d = lat_q - c_LAT_ONE;
        end
      end
      c_RET_REQ: begin
        if (split_grant) begin
          state_d = c_RET_DATA;
        end
      end
      c_RET_DATA: begin
        w_pop = 1'b1;
        if (count_q > c_CNT_ONE) begin
          state_d = c_RET_WAIT;
          lat_d   = c_LAT_LOAD;
        end else begin
          state_d = c_RET_IDLE;
        end
      end
      default: begin
        state_d = c_RET_IDLE;
      end
    endcase
  end

  // Push and pop are mutually exclusive: target_ready is low in RET_DATA.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (w_push) begin
      count_d = count_q + c_CNT_ONE;
      tail_d  = (tail_q == c_PTR_LAST) ? '0 : tail_q + 1'b1;
    end else if (w_pop) begin
      count_d = count_q - c_CNT_ONE;
      head_d  = (head_q == c_PTR_LAST) ? '0 : head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_RET_IDLE;
      lat_q        <= '0;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      resp_q       <= 1'b0;
      ack_q        <= 1'b0;
      split_ack_q  <= 1'b0;
      data_out_q   <= 8'h00;
      last_write_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      resp_q      <= w_wr_acc | w_push;
      ack_q       <= w_wr_acc | w_grant;
      split_ack_q <= w_push;
      data_out_q  <= w_grant ? fifo_q[head_q] : 8'h00;
      if (w_wr_acc) begin
        last_write_q <= target_data_in;
      end
    end
  end

endmodule : split_queue_target
`default_nettype wire

// File: tb/tb_split_queue_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_queue_target
// Description : Scoreboard bench for split_queue_target with a transaction-
//               level reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_queue_target;

  localparam int c_LAT   = 4;
  localparam int c_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ad  = '0;
  logic        av  = 1'b0;
  logic [7:0]  din = '0;
  logic        dv  = 1'b0;
  logic        rw  = 1'b0;
  logic        gin = 1'b0;

  logic        split_req;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        ack;
  logic        split_ack;
  logic        ready;
  logic [7:0]  last_write;

  split_queue_target #(
    .INTERNAL_ADDR_BITS (12),
    .READ_LATENCY       (c_LAT),
    .QUEUE_DEPTH        (c_DEPTH)
  ) u_dut (
    .clk                     (clk),
    .rst                     (rst),
    .target_addr_in          (ad),
    .target_addr_in_valid    (av),
    .target_data_in          (din),
    .target_data_in_valid    (dv),
    .target_rw               (rw),
    .split_grant             (gin),
    .split_req               (split_req),
    .target_data_out         (data_out),
    .target_data_out_valid   (data_out_valid),
    .target_ack              (ack),
    .target_split_ack        (split_ack),
    .target_ready            (ready),
    .split_target_last_write (last_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    bit         ack;
    bit         sack;
    bit         vld;
    logic [7:0] d;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  // Reference model: memory, FIFO of snapshotted bytes, and the cycle from
  // which the head's bus request is due.
  logic [7:0] m_mem [0:4095];
  logic [7:0] m_pend[$];
  bit         m_ready = 1'b1;
  bit         m_req   = 1'b0;
  bit         m_ret   = 1'b0;
  bit         m_resp  = 1'b0;
  int         m_req_from = 0;
  logic [7:0] m_last  = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : model
    bit         acc_wr, acc_rd, g;
    logic [11:0] a;
    ev_t        ev;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend.delete();
        sb.delete();
        m_ready = 1'b1;
        m_req   = 1'b0;
        m_ret   = 1'b0;
        m_resp  = 1'b0;
        m_last  = 8'h00;
      end else begin
        cyc++;
        a      = ad[11:0];
        acc_wr = av && m_ready && rw && dv;
        acc_rd = av && m_ready && !rw;
        g      = m_req && gin;
        if (m_ret) begin
          void'(m_pend.pop_front());
          m_ret = 1'b0;
          if (m_pend.size() > 0) m_req_from = cyc + c_LAT;
        end
        ev.e    = cyc;
        ev.ack  = acc_wr || g;
        ev.sack = acc_rd;
        ev.vld  = g;
        ev.d    = g ? m_pend[0] : 8'h00;
        if (acc_rd) begin
          if (m_pend.size() == 0) m_req_from = cyc + c_LAT;
          m_pend.push_back(m_mem[a]);
        end
        if (acc_wr) begin
          m_mem[a] = din;
          m_last   = din;
        end
        if (g) m_ret = 1'b1;
        m_resp = acc_wr || acc_rd;
        if (ev.ack || ev.sack || ev.vld) sb.push_back(ev);
        m_ready = (m_pend.size() < c_DEPTH) && !m_ret && !m_resp;
        m_req   = (m_pend.size() > 0) && !m_ret && (cyc >= m_req_from);
      end
    end
  end

  initial begin : monitor
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready", ready, m_ready);
        chk("split_req", split_req, m_req);
        chk("last_write", last_write, m_last);
        while (sb.size() > 0 && sb[0].e < cyc) begin
          chk("missing_resp_cycle", cyc, sb[0].e);
          void'(sb.pop_front());
        end
        if (ack || split_ack || data_out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", {ack, split_ack, data_out_valid}, 3'b000);
          end else begin
            ev = sb.pop_front();
            chk("resp_cycle", cyc, ev.e);
            chk("ack", ack, ev.ack);
            chk("split_ack", split_ack, ev.sack);
            chk("data_valid", data_out_valid, ev.vld);
            if (ev.vld) chk("data_out", data_out, ev.d);
          end
        end
      end
    end
  end

  // Holds a request until the DUT accepts it, within a cycle budget.
  task automatic req(input bit w, input logic [15:0] a, input logic [7:0] d);
    bit rdy;
    int n;
    ad = a; rw = w; din = d; av = 1'b1; dv = w;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = ready;
      step();
      n++;
    end
    if (!rdy) chk("req_timeout", rdy, 1'b1);
    av = 1'b0; dv = 1'b0;
  endtask

  task automatic wait_split_req();
    int n;
    n = 0;
    while (!split_req && n < 50) begin
      step();
      n++;
    end
    chk("split_req_wait", split_req, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_split_req"}, split_req, 1'b0);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_data_valid"}, data_out_valid, 1'b0);
    chk({tag, "_ack"}, ack, 1'b0);
    chk({tag, "_split_ack"}, split_ack, 1'b0);
    chk({tag, "_last_write"}, last_write, 8'h00);
  endtask

  initial begin : driver
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Preload every location the stimulus may read.
    gin = 1'b1;
    for (int i = 0; i < 16; i++) req(1'b1, 16'(i), 8'(i * 7 + 3));

    // Write then read through the aliased address, grant held high.
    req(1'b1, 16'h800A, 8'h6D);
    req(1'b0, 16'h800A, 8'h00);
    repeat (10) step();

    // Two reads two cycles apart, returned in order.
    req(1'b1, 16'h8001, 8'h11);
    req(1'b1, 16'h8002, 8'h22);
    req(1'b0, 16'h8001, 8'h00);
    req(1'b0, 16'h8002, 8'h00);
    repeat (20) step();

    // Three back-to-back reads with grant low; third waits for a return.
    gin = 1'b0;
    req(1'b0, 16'h0003, 8'h00);
    req(1'b0, 16'h0004, 8'h00);
    fork
      req(1'b0, 16'h0006, 8'h00);
      begin
        repeat (12) step();
        gin = 1'b1;
      end
    join
    repeat (25) step();

    // Grant delayed seven cycles after the request.
    gin = 1'b0;
    req(1'b0, 16'h0007, 8'h00);
    wait_split_req();
    repeat (7) step();
    gin = 1'b1;
    repeat (5) step();

    // Queued read is unaffected by a later write to the same address.
    gin = 1'b0;
    req(1'b1, 16'h8005, 8'h33);
    req(1'b0, 16'h8005, 8'h00);
    req(1'b1, 16'h8005, 8'h44);
    gin = 1'b1;
    repeat (10) step();
    req(1'b0, 16'h8005, 8'h00);
    repeat (10) step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      av  = ($urandom % 3) == 0;
      rw  = 1'($urandom % 2);
      dv  = ($urandom % 4) != 0;
      ad  = {4'($urandom), 8'h00, 4'($urandom)};
      din = 8'($urandom);
      gin = ($urandom % 3) != 0;
      step();
    end
    av = 1'b0; dv = 1'b0; gin = 1'b1;
    repeat (40) step();
    chk("drain_scoreboard", sb.size(), 0);

    // Reset while a return is requested with two reads pending.
    gin = 1'b0;
    req(1'b0, 16'h8001, 8'h00);
    req(1'b0, 16'h8002, 8'h00);
    wait_split_req();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    step();
    rst = 1'b0;
    gin = 1'b1;
    repeat (15) step();
    req(1'b0, 16'h8002, 8'h00);
    repeat (12) step();
    chk("final_scoreboard", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_split_queue_target
`default_nettype wire
